// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with load-use hazard detection, bubble
// injection, downstream hold, branch flush and saturating event counters.
module id_ex_stage #(
  parameter int              DW       = 32,
  parameter int              IW       = 32,
  parameter int              RFW      = 5,
  parameter int              CW       = 16,
  parameter logic [IW-1:0]   NOP_INST = 32'h00000013
) (
  input  logic          clk,
  input  logic          idex_reset_n,
  input  logic          id_valid,
  input  logic [IW-1:0] id_inst,
  input  logic [DW-1:0] id_pc,
  input  logic [DW-1:0] id_imm,
  input  logic [DW-1:0] reg1data,
  input  logic [DW-1:0] reg2data,
  input  logic          mem_stall,
  input  logic          ex_flush,
  output logic          id_stall,
  output logic          ex_valid,
  output logic [IW-1:0] ex_inst,
  output logic [DW-1:0] ex_pc,
  output logic [DW-1:0] ex_rs1data,
  output logic [DW-1:0] ex_rs2data,
  output logic [DW-1:0] ex_imm,
  output logic [CW-1:0] bubble_cnt,
  output logic [CW-1:0] flush_cnt
);

  localparam logic [6:0] OP_LOAD = 7'h03;

  logic          ex_valid_q,   ex_valid_d;
  logic [IW-1:0] ex_inst_q,    ex_inst_d;
  logic [DW-1:0] ex_pc_q,      ex_pc_d;
  logic [DW-1:0] ex_rs1_q,     ex_rs1_d;
  logic [DW-1:0] ex_rs2_q,     ex_rs2_d;
  logic [DW-1:0] ex_imm_q,     ex_imm_d;
  logic [CW-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CW-1:0] flush_cnt_q,  flush_cnt_d;

  logic [6:0]     id_op;
  logic [RFW-1:0] id_rs1, id_rs2, ex_rd;
  logic           id_use_rs1, id_use_rs2;
  logic           ex_is_load;
  logic           load_use;

  always_comb begin
    id_op      = id_inst[6:0];
    id_rs1     = id_inst[15 +: RFW];
    id_rs2     = id_inst[20 +: RFW];
    ex_rd      = ex_inst_q[7 +: RFW];
    id_use_rs1 = id_op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
    id_use_rs2 = id_op inside {7'h33, 7'h23, 7'h63};
    ex_is_load = ex_valid_q && (ex_inst_q[6:0] == OP_LOAD) && (ex_rd != '0);
    load_use   = ex_is_load && id_valid &&
                 ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    id_stall   = (load_use && !ex_flush) || mem_stall;
  end

  always_comb begin
    // NOTE: every _d gets a hold default first so no path through this block infers a latch.
    ex_valid_d   = ex_valid_q;
    ex_inst_d    = ex_inst_q;
    ex_pc_d      = ex_pc_q;
    ex_rs1_d     = ex_rs1_q;
    ex_rs2_d     = ex_rs2_q;
    ex_imm_d     = ex_imm_q;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;

    if (ex_flush || (!mem_stall && load_use)) begin
      ex_valid_d = 1'b0;
      ex_inst_d  = NOP_INST;
      ex_pc_d    = '0;
      ex_rs1_d   = '0;
      ex_rs2_d   = '0;
      ex_imm_d   = '0;
    end else if (!mem_stall) begin
      ex_valid_d = id_valid;
      ex_inst_d  = id_valid ? id_inst : NOP_INST;
      ex_pc_d    = id_pc;
      ex_rs1_d   = reg1data;
      ex_rs2_d   = reg2data;
      ex_imm_d   = id_imm;
    end

    // A flush wins over a hold; a hazard only counts when the stage actually advances.
    if (ex_flush) begin
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CW'(1);
    end else if (!mem_stall && load_use) begin
      if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + CW'(1);
    end
  end

  // NOTE: state is updated with non-blocking assignments only; the datapath is
  // reset too because ex_inst feeds forwarding logic and must never be X.
  always_ff @(posedge clk) begin
    if (!idex_reset_n) begin
      ex_valid_q   <= 1'b0;
      ex_inst_q    <= NOP_INST;
      ex_pc_q      <= '0;
      ex_rs1_q     <= '0;
      ex_rs2_q     <= '0;
      ex_imm_q     <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_inst_q    <= ex_inst_d;
      ex_pc_q      <= ex_pc_d;
      ex_rs1_q     <= ex_rs1_d;
      ex_rs2_q     <= ex_rs2_d;
      ex_imm_q     <= ex_imm_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_inst    = ex_inst_q;
  assign ex_pc      = ex_pc_q;
  assign ex_rs1data = ex_rs1_q;
  assign ex_rs2data = ex_rs2_q;
  assign ex_imm     = ex_imm_q;
  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: a behavioural EXE-slot model checked every cycle, plus
// directed scenarios with literal expectations. A CW=4 twin shows saturation.
module tb_id_ex_stage;

  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] ADD  = 32'h002081B3; // add x3,x1,x2
  localparam logic [31:0] LW2  = 32'h0000A103; // lw x2,0(x1)
  localparam logic [31:0] LW0  = 32'h0000A003; // lw x0,0(x1)
  localparam logic [31:0] ADD0 = 32'h000001B3; // add x3,x0,x0
  localparam logic [31:0] ADDI = 32'h00208293; // addi x5,x1,2 (rs2 field = 2)
  localparam logic [31:0] SW   = 32'h0021A023; // sw x2,0(x3)
  localparam logic [31:0] LWS  = 32'h00012103; // lw x2,0(x2)

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, mem_stall, ex_flush;
  logic [31:0] id_inst, id_pc, id_imm, reg1data, reg2data;

  logic        id_stall, ex_valid;
  logic [31:0] ex_inst, ex_pc, ex_rs1data, ex_rs2data, ex_imm;
  logic [15:0] bubble_cnt, flush_cnt;

  logic        s_id_stall, s_ex_valid;
  logic [31:0] s_ex_inst, s_ex_pc, s_ex_rs1data, s_ex_rs2data, s_ex_imm;
  logic [3:0]  s_bubble_cnt, s_flush_cnt;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .idex_reset_n(rst_n), .id_valid(id_valid), .id_inst(id_inst),
    .id_pc(id_pc), .id_imm(id_imm), .reg1data(reg1data), .reg2data(reg2data),
    .mem_stall(mem_stall), .ex_flush(ex_flush), .id_stall(id_stall),
    .ex_valid(ex_valid), .ex_inst(ex_inst), .ex_pc(ex_pc),
    .ex_rs1data(ex_rs1data), .ex_rs2data(ex_rs2data), .ex_imm(ex_imm),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  id_ex_stage #(.CW(4)) u_sat (
    .clk(clk), .idex_reset_n(rst_n), .id_valid(id_valid), .id_inst(id_inst),
    .id_pc(id_pc), .id_imm(id_imm), .reg1data(reg1data), .reg2data(reg2data),
    .mem_stall(mem_stall), .ex_flush(ex_flush), .id_stall(s_id_stall),
    .ex_valid(s_ex_valid), .ex_inst(s_ex_inst), .ex_pc(s_ex_pc),
    .ex_rs1data(s_ex_rs1data), .ex_rs2data(s_ex_rs2data), .ex_imm(s_ex_imm),
    .bubble_cnt(s_bubble_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: the instruction sitting in EXE plus plain event tallies.
  bit          m_known = 0;
  logic        m_valid;
  logic [31:0] m_inst, m_pc, m_rs1, m_rs2, m_imm;
  int          m_bubbles, m_flushes;

  function automatic bit reads_reg(input logic [31:0] inst, input logic [4:0] r);
    logic [6:0] op;
    op = inst[6:0];
    return (op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67} && inst[19:15] == r) ||
           (op inside {7'h33, 7'h23, 7'h63} && inst[24:20] == r);
  endfunction

  function automatic bit model_load_use();
    return m_valid && m_inst[6:0] == 7'h03 && m_inst[11:7] != 5'd0 &&
           id_valid && reads_reg(id_inst, m_inst[11:7]);
  endfunction

  function automatic logic [63:0] sat(input int n, input int w);
    int top;
    top = (1 << w) - 1;
    return (n > top) ? 64'(top) : 64'(n);
  endfunction

  task automatic model_bubble();
    m_valid = 0; m_inst = NOP; m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0;
  endtask

  always @(posedge clk) begin
    bit lu;
    lu = model_load_use();
    if (!rst_n) begin
      model_bubble();
      m_bubbles = 0;
      m_flushes = 0;
      m_known   = 1;
    end else if (ex_flush) begin
      model_bubble();
      m_flushes++;
    end else if (!mem_stall) begin
      if (lu) begin
        model_bubble();
        m_bubbles++;
      end else begin
        m_valid = id_valid;
        m_inst  = id_valid ? id_inst : NOP;
        m_pc    = id_pc;
        m_rs1   = reg1data;
        m_rs2   = reg2data;
        m_imm   = id_imm;
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      logic exp_stall;
      exp_stall = (model_load_use() && !ex_flush) || mem_stall;
      check("m_id_stall",   id_stall,     exp_stall);
      check("m_ex_valid",   ex_valid,     m_valid);
      check("m_ex_inst",    ex_inst,      m_inst);
      check("m_ex_pc",      ex_pc,        m_pc);
      check("m_ex_rs1",     ex_rs1data,   m_rs1);
      check("m_ex_rs2",     ex_rs2data,   m_rs2);
      check("m_ex_imm",     ex_imm,       m_imm);
      check("m_bubble_cnt", bubble_cnt,   sat(m_bubbles, 16));
      check("m_flush_cnt",  flush_cnt,    sat(m_flushes, 16));
      check("s_id_stall",   s_id_stall,   exp_stall);
      check("s_ex_inst",    s_ex_inst,    m_inst);
      check("s_bubble_cnt", s_bubble_cnt, sat(m_bubbles, 4));
      check("s_flush_cnt",  s_flush_cnt,  sat(m_flushes, 4));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm);
    id_valid = 1; id_inst = inst; id_pc = pc; reg1data = r1; reg2data = r2; id_imm = imm;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, ex_valid,   1'b0);
    check({tag, "_inst"},  ex_inst,    NOP);
    check({tag, "_pc"},    ex_pc,      32'h0);
    check({tag, "_rs1"},   ex_rs1data, 32'h0);
    check({tag, "_rs2"},   ex_rs2data, 32'h0);
    check({tag, "_imm"},   ex_imm,     32'h0);
    check({tag, "_bcnt"},  bubble_cnt, 16'h0);
    check({tag, "_fcnt"},  flush_cnt,  16'h0);
  endtask

  initial begin
    // Reset with junk on every input, including flush and stall.
    rst_n = 0; mem_stall = 1; ex_flush = 1;
    drive(32'hDEADBEEF, 32'h1234, 32'hAAAA, 32'hBBBB, 32'hCCCC);
    tick(); tick();
    check_reset_state("rst");

    // Pass-through of an add.
    rst_n = 1; mem_stall = 0; ex_flush = 0;
    drive(ADD, 32'h40, 32'd5, 32'd7, 32'h0);
    #1 check("pass_stall", id_stall, 1'b0);
    tick();
    check("pass_inst",  ex_inst,    ADD);
    check("pass_rs1",   ex_rs1data, 32'd5);
    check("pass_rs2",   ex_rs2data, 32'd7);
    check("pass_pc",    ex_pc,      32'h40);
    check("pass_valid", ex_valid,   1'b1);

    // Load-use: lw x2 in EXE, add reading x2 in decode.
    drive(LW2, 32'h44, 32'h100, 32'h0, 32'h0);
    tick();
    drive(ADD, 32'h48, 32'd5, 32'd9, 32'h0);
    #1 check("lu_stall", id_stall, 1'b1);
    tick();
    check("lu_bubble_inst",  ex_inst,    NOP);
    check("lu_bubble_valid", ex_valid,   1'b0);
    check("lu_bcnt",         bubble_cnt, 16'd1);
    check("lu_replay_stall", id_stall,   1'b0);
    tick();
    check("lu_replay_inst", ex_inst, ADD);
    check("lu_replay_pc",   ex_pc,   32'h48);

    // No false hazard: load to x0.
    drive(LW0, 32'h4C, 32'h0, 32'h0, 32'h0);
    tick();
    drive(ADD0, 32'h50, 32'h0, 32'h0, 32'h0);
    #1 check("x0_stall", id_stall, 1'b0);
    tick();
    check("x0_inst", ex_inst,    ADD0);
    check("x0_bcnt", bubble_cnt, 16'd1);

    // No false hazard: I-type whose rs2 field equals the load's rd.
    drive(LW2, 32'h54, 32'h0, 32'h0, 32'h0);
    tick();
    drive(ADDI, 32'h58, 32'h0, 32'h0, 32'h2);
    #1 check("itype_stall", id_stall, 1'b0);
    tick();
    check("itype_inst", ex_inst,    ADDI);
    check("itype_bcnt", bubble_cnt, 16'd1);

    // Store reading the loaded register through rs2 is a real hazard.
    drive(LW2, 32'h5C, 32'h0, 32'h0, 32'h0);
    tick();
    drive(SW, 32'h60, 32'h0, 32'h0, 32'h0);
    #1 check("sw_stall", id_stall, 1'b1);
    tick();
    check("sw_bcnt", bubble_cnt, 16'd2);
    tick();
    check("sw_inst", ex_inst, SW);

    // Flush masks a load-use stall.
    drive(LW2, 32'h64, 32'h0, 32'h0, 32'h0);
    tick();
    drive(ADD, 32'h68, 32'h0, 32'h0, 32'h0);
    ex_flush = 1;
    #1 check("flu_stall", id_stall, 1'b0);
    tick();
    check("flu_fcnt", flush_cnt, 16'd1);
    check("flu_inst", ex_inst,   NOP);
    ex_flush = 0;
    tick();

    // Flush beats a simultaneous hold.
    ex_flush = 1; mem_stall = 1;
    #1 check("fbs_stall", id_stall, 1'b1);
    tick();
    check("fbs_valid", ex_valid,  1'b0);
    check("fbs_inst",  ex_inst,   NOP);
    check("fbs_fcnt",  flush_cnt, 16'd2);

    // Hold alone for three cycles.
    ex_flush = 0; mem_stall = 0;
    drive(ADD, 32'h80, 32'h11, 32'h22, 32'h33);
    tick();
    mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      drive(LW2, 32'h90 + 32'(i), 32'hF0 + 32'(i), 32'hE0, 32'hD0);
      tick();
      check("hold_inst",  ex_inst,    ADD);
      check("hold_pc",    ex_pc,      32'h80);
      check("hold_rs1",   ex_rs1data, 32'h11);
      check("hold_rs2",   ex_rs2data, 32'h22);
      check("hold_imm",   ex_imm,     32'h33);
      check("hold_stall", id_stall,   1'b1);
    end
    mem_stall = 0;

    // Flush of an empty slot still counts.
    id_valid = 0;
    tick();
    check("inv_inst", ex_inst, NOP);
    ex_flush = 1;
    tick();
    check("inv_fcnt", flush_cnt, 16'd3);
    ex_flush = 0;

    // Self-dependent load repeats a hazard every other cycle: 20 bubbles.
    drive(LWS, 32'hA0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 40; i++) tick();
    check("sat_bcnt_main", bubble_cnt,   16'd22);
    check("sat_bcnt_cw4",  s_bubble_cnt, 4'hF);

    ex_flush = 1;
    for (int i = 0; i < 20; i++) tick();
    check("sat_fcnt_main", flush_cnt,   16'd23);
    check("sat_fcnt_cw4",  s_flush_cnt, 4'hF);
    ex_flush = 0;

    // Reset in the middle of a hold.
    drive(ADD, 32'hB0, 32'h1, 32'h2, 32'h3);
    tick();
    check("pre_rst_inst", ex_inst, ADD);
    mem_stall = 1; rst_n = 0;
    tick();
    check_reset_state("rst2");
    check("rst2_cw4_bcnt", s_bubble_cnt, 4'h0);
    rst_n = 1; mem_stall = 0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
